// File: rtl/ir_sched_pkg.sv
// Shared types, channel map and weighting helpers for the IR line-sensor A2D scheduler.
package ir_sched_pkg;

    localparam int unsigned TMR_W = 16;
    localparam int unsigned ACC_W = 17;
    localparam int unsigned ERR_W = 16;
    localparam int unsigned RES_W = 12;
    localparam int unsigned CH_W  = 3;

    typedef enum logic [2:0] {
        IDLE, SETTLE, STRT_R, WAIT_R, STRT_L, WAIT_L, NEXT, DONE
    } state_t;

    localparam logic [CH_W-1:0] CH_IN_R  = 3'd1;
    localparam logic [CH_W-1:0] CH_IN_L  = 3'd0;
    localparam logic [CH_W-1:0] CH_MID_R = 3'd4;
    localparam logic [CH_W-1:0] CH_MID_L = 3'd2;
    localparam logic [CH_W-1:0] CH_OUT_R = 3'd3;
    localparam logic [CH_W-1:0] CH_OUT_L = 3'd7;

    localparam logic [1:0] PAIR_LAST = 2'd2;

    localparam logic [1:0] SHIFT_IN  = 2'd0;
    localparam logic [1:0] SHIFT_MID = 2'd1;
    localparam logic [1:0] SHIFT_OUT = 2'd3;

    localparam logic signed [ERR_W-1:0] ERR_MAX = 16'sh7FFF;
    localparam logic signed [ERR_W-1:0] ERR_MIN = 16'sh8000;
    localparam logic signed [ACC_W-1:0] ACC_MAX = 17'sd32767;
    localparam logic signed [ACC_W-1:0] ACC_MIN = -17'sd32768;

    function automatic logic [CH_W-1:0] ch_right(input logic [1:0] pair);
        case (pair)
            2'd0:    return CH_IN_R;
            2'd1:    return CH_MID_R;
            default: return CH_OUT_R;
        endcase
    endfunction

    function automatic logic [CH_W-1:0] ch_left(input logic [1:0] pair);
        case (pair)
            2'd0:    return CH_IN_L;
            2'd1:    return CH_MID_L;
            default: return CH_OUT_L;
        endcase
    endfunction

    function automatic logic [1:0] pair_shift(input logic [1:0] pair);
        case (pair)
            2'd0:    return SHIFT_IN;
            2'd1:    return SHIFT_MID;
            default: return SHIFT_OUT;
        endcase
    endfunction

    // Weighted magnitude of one conversion; 0xFFF << 3 still fits the accumulator.
    function automatic logic [ACC_W-1:0] weigh(input logic [RES_W-1:0] res, input logic [1:0] pair);
        return ACC_W'(res) << pair_shift(pair);
    endfunction

    function automatic logic signed [ERR_W-1:0] sat16(input logic signed [ACC_W-1:0] a);
        if (a > ACC_MAX)
            return ERR_MAX;
        else if (a < ACC_MIN)
            return ERR_MIN;
        else
            return a[ERR_W-1:0];
    endfunction

endpackage

// File: rtl/ir_a2d_sched_if.sv
// A2D converter handshake: start/channel toward the converter, done/result back.
interface ir_a2d_sched_if;
    import ir_sched_pkg::*;

    logic             strt_cnv;
    logic [CH_W-1:0]  chnnl;
    logic             cnv_cmplt;
    logic [RES_W-1:0] A2D_res;

    modport master (output strt_cnv, output chnnl, input cnv_cmplt, input A2D_res);
    modport slave  (input strt_cnv, input chnnl, output cnv_cmplt, output A2D_res);

endinterface

// File: rtl/ir_sched_tmr.sv
// Loadable up-counter with terminal match, shared by emitter settle and conversion timeout.
module ir_sched_tmr
    import ir_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic [TMR_W-1:0] term,
    output logic             match_c
);

    logic [TMR_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (ld)
            cnt <= '0;
        else
            cnt <= cnt + TMR_W'(1);
    end

    assign match_c = (cnt == term);

endmodule

// File: rtl/ir_a2d_sched.sv
// Round-robin A2D scheduler over three IR emitter pairs, folding results into a
// weighted, saturated signed steering error.
module ir_a2d_sched
    import ir_sched_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 4096,
    parameter int unsigned CNV_TMO    = 65535
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    go,
    ir_a2d_sched_if.master          a2d,
    output logic                    IR_in_en,
    output logic                    IR_mid_en,
    output logic                    IR_out_en,
    output logic                    busy,
    output logic signed [ERR_W-1:0] err,
    output logic                    err_vld,
    output logic                    tmo
);

    localparam logic [TMR_W-1:0] SETTLE_TERM = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] TMO_TERM    = TMR_W'(CNV_TMO - 1);

    state_t                  state, state_nxt;
    logic [1:0]              pair, pair_nxt;
    logic signed [ACC_W-1:0] accum, accum_nxt;
    logic signed [ERR_W-1:0] err_nxt;
    logic                    err_vld_nxt, tmo_nxt, strt_nxt, busy_nxt;
    logic [CH_W-1:0]         chnnl_q, chnnl_nxt;
    logic                    strt_q;
    logic [2:0]              en_q, en_nxt;
    logic                    tmr_ld, tmr_match;
    logic [TMR_W-1:0]        tmr_term;

    ir_sched_tmr u_tmr (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld      (tmr_ld),
        .term    (tmr_term),
        .match_c (tmr_match)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pair    <= '0;
            accum   <= '0;
            err     <= '0;
            err_vld <= 1'b0;
            tmo     <= 1'b0;
            strt_q  <= 1'b0;
            chnnl_q <= '0;
            busy    <= 1'b0;
            en_q    <= '0;
        end else begin
            state   <= state_nxt;
            pair    <= pair_nxt;
            accum   <= accum_nxt;
            err     <= err_nxt;
            err_vld <= err_vld_nxt;
            tmo     <= tmo_nxt;
            strt_q  <= strt_nxt;
            chnnl_q <= chnnl_nxt;
            busy    <= busy_nxt;
            en_q    <= en_nxt;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        state_nxt   = state;
        pair_nxt    = pair;
        accum_nxt   = accum;
        err_nxt     = err;
        err_vld_nxt = 1'b0;
        tmo_nxt     = 1'b0;
        strt_nxt    = 1'b0;
        chnnl_nxt   = chnnl_q;
        busy_nxt    = 1'b0;
        en_nxt      = '0;
        tmr_ld      = 1'b0;
        tmr_term    = TMO_TERM;

        case (state)
            IDLE: begin
                if (go) begin
                    accum_nxt = '0;
                    pair_nxt  = '0;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                tmr_term = SETTLE_TERM;
                if (tmr_match)
                    state_nxt = STRT_R;
            end
            STRT_R: state_nxt = WAIT_R;
            WAIT_R: begin
                if (a2d.cnv_cmplt) begin
                    accum_nxt = accum + weigh(a2d.A2D_res, pair);
                    state_nxt = STRT_L;
                end else if (tmr_match) begin
                    tmo_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            STRT_L: state_nxt = WAIT_L;
            WAIT_L: begin
                if (a2d.cnv_cmplt) begin
                    accum_nxt = accum - weigh(a2d.A2D_res, pair);
                    state_nxt = NEXT;
                end else if (tmr_match) begin
                    tmo_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            NEXT: begin
                if (pair < PAIR_LAST) begin
                    pair_nxt  = pair + 2'd1;
                    state_nxt = SETTLE;
                end else begin
                    err_nxt     = sat16(accum);
                    err_vld_nxt = 1'b1;
                    state_nxt   = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        strt_nxt = (state_nxt == STRT_R) || (state_nxt == STRT_L);
        if (state_nxt == STRT_R)
            chnnl_nxt = ch_right(pair_nxt);
        else if (state_nxt == STRT_L)
            chnnl_nxt = ch_left(pair_nxt);

        busy_nxt = (state_nxt != IDLE) && (state_nxt != DONE);
        if ((state_nxt == SETTLE) || (state_nxt == STRT_R) || (state_nxt == WAIT_R) ||
            (state_nxt == STRT_L) || (state_nxt == WAIT_L))
            en_nxt = 3'b001 << pair_nxt;

        // Counter restarts on entry to SETTLE and on every conversion start.
        tmr_ld = ((state_nxt == SETTLE) && (state != SETTLE)) || strt_nxt;
    end

    assign a2d.strt_cnv = strt_q;
    assign a2d.chnnl    = chnnl_q;
    assign IR_in_en     = en_q[0];
    assign IR_mid_en    = en_q[1];
    assign IR_out_en    = en_q[2];

endmodule

// File: tb/tb_ir_a2d_sched.sv
// Directed bench for ir_a2d_sched with a delayed-reply converter model.
module tb_ir_a2d_sched;
    import ir_sched_pkg::*;

    localparam int unsigned S        = 8;
    localparam int unsigned TMO      = 20;
    localparam int unsigned PAIR_CYC = S + 13;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic go    = 1'b0;
    logic IR_in_en, IR_mid_en, IR_out_en, busy, err_vld, tmo;
    logic signed [15:0] err;

    ir_a2d_sched_if a2d ();

    ir_a2d_sched #(.SETTLE_CYC(S), .CNV_TMO(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .go        (go),
        .a2d       (a2d),
        .IR_in_en  (IR_in_en),
        .IR_mid_en (IR_mid_en),
        .IR_out_en (IR_out_en),
        .busy      (busy),
        .err       (err),
        .err_vld   (err_vld),
        .tmo       (tmo)
    );

    always #10 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Converter model: replies rsp_dly cycles after strt_cnv unless the channel is dropped.
    logic [11:0] res_tbl [8];
    int          rsp_dly = 5;
    int          drop_ch = 8;
    bit          pend    = 1'b0;
    int          rem     = 0;
    logic [2:0]  pend_ch = '0;

    always @(negedge clk) begin
        a2d.cnv_cmplt = 1'b0;
        if (pend) begin
            rem = rem - 1;
            if (rem <= 0) begin
                a2d.cnv_cmplt = 1'b1;
                a2d.A2D_res   = res_tbl[pend_ch];
                pend          = 1'b0;
            end
        end
        if (a2d.strt_cnv && int'(a2d.chnnl) != drop_ch) begin
            pend    = 1'b1;
            rem     = rsp_dly;
            pend_ch = a2d.chnnl;
        end
    end

    // Activity monitor.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_vld = 0, n_tmo = 0, n_mis = 0, n_strt = 0, vld_cyc = 0, tmo_cyc = 0;
    int         en_cnt [3] = '{0, 0, 0};
    int         strt_cyc_q [$];
    logic [2:0] ch_q [$];

    function automatic logic [2:0] exp_en(input logic [2:0] ch);
        case (ch)
            3'd1, 3'd0: return 3'b001;
            3'd4, 3'd2: return 3'b010;
            3'd3, 3'd7: return 3'b100;
            default:    return 3'b000;
        endcase
    endfunction

    always @(negedge clk) begin
        if (err_vld) begin n_vld++; vld_cyc = cyc; end
        if (tmo)     begin n_tmo++; tmo_cyc = cyc; end
        if (IR_in_en)  en_cnt[0]++;
        if (IR_mid_en) en_cnt[1]++;
        if (IR_out_en) en_cnt[2]++;
        if ($countones({IR_out_en, IR_mid_en, IR_in_en}) > 1) n_mis++;
        if (a2d.strt_cnv) begin
            n_strt++;
            strt_cyc_q.push_back(cyc);
            ch_q.push_back(a2d.chnnl);
            if ({IR_out_en, IR_mid_en, IR_in_en} != exp_en(a2d.chnnl)) n_mis++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_go(output int g);
        step();
        go = 1'b1;
        g  = cyc;
        step();
        go = 1'b0;
    endtask

    task automatic set_res(input logic [11:0] r, input logic [11:0] l);
        for (int i = 0; i < 8; i++) res_tbl[i] = 12'h000;
        res_tbl[1] = r; res_tbl[4] = r; res_tbl[3] = r;
        res_tbl[0] = l; res_tbl[2] = l; res_tbl[7] = l;
    endtask

    task automatic wait_vld(input int base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            step();
            ok = (n_vld > base);
        end
    endtask

    task automatic run_sweep(input string tag, input logic [15:0] exp_err);
        int g, bv;
        bit ok;
        bv = n_vld;
        pulse_go(g);
        wait_vld(bv, ok);
        chk({tag, "_vld_seen"}, 32'(ok), 32'd1);
        chk({tag, "_err"}, {16'h0, err}, {16'h0, exp_err});
    endtask

    initial begin
        int  g, bs, bv, bt, bn, bm, b0, b1;
        bit  ok;
        logic [17:0] seq;

        set_res(12'h800, 12'h800);
        step(3);
        chk("reset_outs", {24'h0, busy, a2d.strt_cnv, a2d.chnnl, err_vld, tmo},
            32'h0);
        chk("reset_en_err", {13'h0, IR_out_en, IR_mid_en, IR_in_en, err}, 32'h0);
        rst_n = 1'b1;
        step(2);

        // Balanced sweep with a second go inside SETTLE.
        bs = strt_cyc_q.size(); bv = n_vld; bn = n_strt; bm = n_mis;
        b0 = en_cnt[0]; b1 = en_cnt[1];
        pulse_go(g);
        step(2);
        chk("busy_in_settle", 32'(busy), 32'd1);
        go = 1'b1; step(); go = 1'b0;
        wait_vld(bv, ok);
        chk("bal_vld_seen", 32'(ok), 32'd1);
        chk("bal_err", {16'h0, err}, 32'h0);
        chk("first_strt_lat", 32'(strt_cyc_q[bs] - g), 32'(S + 1));
        chk("sweep_len", 32'(vld_cyc - g), 32'(3 * PAIR_CYC + 1));
        seq = {ch_q[bs], ch_q[bs+1], ch_q[bs+2], ch_q[bs+3], ch_q[bs+4], ch_q[bs+5]};
        chk("chnnl_seq", 32'(seq), 32'({3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7}));
        step();
        chk("busy_after", 32'(busy), 32'd0);
        step(30);
        chk("strt_count", 32'(n_strt - bn), 32'd6);
        chk("vld_count", 32'(n_vld - bv), 32'd1);
        chk("en_in_cycles", 32'(en_cnt[0] - b0), 32'(S + 12));
        chk("en_mid_cycles", 32'(en_cnt[1] - b1), 32'(S + 12));
        chk("en_pair_match", 32'(n_mis - bm), 32'd0);

        // Inner-right only.
        set_res(12'h000, 12'h000);
        res_tbl[1] = 12'hFFF;
        bm = n_mis;
        run_sweep("inner_r", 16'h0FFF);
        chk("inner_en_match", 32'(n_mis - bm), 32'd0);
        step(3);

        // Saturation both ways.
        set_res(12'hFFF, 12'h000);
        run_sweep("sat_pos", 16'h7FFF);
        step(3);
        set_res(12'h000, 12'hFFF);
        run_sweep("sat_neg", 16'h8000);
        step(3);

        // Timeout on the mid-right conversion.
        set_res(12'h800, 12'h800);
        drop_ch = 4;
        bs = strt_cyc_q.size(); bv = n_vld; bt = n_tmo;
        pulse_go(g);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            step();
            ok = (n_tmo > bt);
        end
        chk("tmo_seen", 32'(ok), 32'd1);
        chk("tmo_state", {27'h0, tmo, busy, IR_out_en, IR_mid_en, IR_in_en}, 32'h10);
        chk("tmo_lat", 32'(tmo_cyc - strt_cyc_q[bs+2]), 32'(TMO));
        chk("tmo_chnnl_held", 32'(a2d.chnnl), 32'd4);
        chk("tmo_err_held", {16'h0, err}, 32'h8000);
        bn = n_strt;
        step(10);
        chk("tmo_no_vld", 32'(n_vld - bv), 32'd0);
        chk("tmo_single", 32'(n_tmo - bt), 32'd1);
        chk("tmo_idle", 32'(n_strt - bn), 32'd0);
        drop_ch = 8;

        // Reset while the mid pair's left conversion is outstanding.
        bs = ch_q.size(); bv = n_vld; bt = n_tmo;
        pulse_go(g);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            step();
            ok = (ch_q.size() >= bs + 4);
        end
        chk("mid_l_seen", 32'(ok), 32'd1);
        chk("mid_l_chnnl", 32'(ch_q[bs+3]), 32'd2);
        step(2);
        rst_n = 1'b0;
        step();
        chk("rst_mid_outs", {23'h0, busy, a2d.strt_cnv, a2d.chnnl, err_vld, tmo,
            IR_out_en, IR_mid_en, IR_in_en}, 32'h0);
        chk("rst_mid_err", {16'h0, err}, 32'h0);
        rst_n = 1'b1;
        bn = n_strt;
        step(12);
        chk("stray_no_strt", 32'(n_strt - bn), 32'd0);
        chk("stray_idle", {28'h0, busy, IR_out_en, IR_mid_en, IR_in_en}, 32'h0);
        chk("stray_err", {16'h0, err}, 32'h0);
        chk("stray_no_pulses", 32'((n_vld - bv) + (n_tmo - bt)), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
